// File: rtl/lr35902_dbg_snapshot.sv
// Debug snapshot stage for the LR35902 debug UART.
// Captures PC/SP/F/IME/probe on every advancing opcode fetch while the CPU runs,
// and freezes them while halted so the debug port serialises stable values.
// Also records recent fetch PCs in a ring buffer that can be popped while
// halted, and counts captured fetches.
module lr35902_dbg_snapshot #(
  parameter int TRACE_AW = 4,
  parameter int CNT_W    = 32
) (
  input  logic                cpu_clk,
  input  logic                reset,
  input  logic                fetch,
  input  logic                halt,
  input  logic [15:0]         pc_in,
  input  logic [15:0]         sp_in,
  input  logic [3:0]          f_in,
  input  logic                ime_in,
  input  logic [7:0]          probe_in,
  output logic [15:0]         pc,
  output logic [15:0]         sp,
  output logic [3:0]          f,
  output logic                ime,
  output logic [7:0]          probe,
  input  logic                trace_rd,
  input  logic                trace_clr,
  output logic [15:0]         trace_data,
  output logic                trace_valid,
  output logic [TRACE_AW:0]   trace_cnt,
  output logic                trace_wrap,
  output logic [CNT_W-1:0]    fetch_cnt
);

  localparam int DEPTH = 1 << TRACE_AW;
  localparam logic [TRACE_AW:0] DEPTH_CNT = (TRACE_AW + 1)'(DEPTH);

  // Snapshot registers
  logic [15:0]         pc_q, pc_d;
  logic [15:0]         sp_q, sp_d;
  logic [3:0]          f_q, f_d;
  logic                ime_q, ime_d;
  logic [7:0]          probe_q, probe_d;

  // Trace ring buffer state
  logic [TRACE_AW-1:0] wptr_q, wptr_d;
  logic [TRACE_AW-1:0] rptr_q, rptr_d;
  logic [TRACE_AW:0]   cnt_q, cnt_d;
  logic                wrap_q, wrap_d;
  logic [15:0]         data_q, data_d;
  logic                valid_q, valid_d;
  logic [CNT_W-1:0]    fcnt_q, fcnt_d;

  logic [15:0]         mem [DEPTH];

  logic cap;
  logic full;
  logic push;
  logic pop;

  // A fetch only counts as captured while the CPU is running; clear
  // suppresses both push and pop so the buffer really ends up empty.
  assign cap  = fetch & ~halt;
  assign full = (cnt_q == DEPTH_CNT);
  assign push = cap & ~trace_clr;
  assign pop  = trace_rd & halt & (cnt_q != '0) & ~trace_clr;

  // Trace storage write port: no reset so it maps onto RAM.
  always_ff @(posedge cpu_clk) begin
    if (push) begin
      mem[wptr_q] <= pc_in;
    end
  end

  // Next-state logic for snapshot, counter and ring-buffer bookkeeping.
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    f_d     = f_q;
    ime_d   = ime_q;
    probe_d = probe_q;
    fcnt_d  = fcnt_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    wrap_d  = wrap_q;
    data_d  = data_q;
    valid_d = 1'b0;

    if (cap) begin
      pc_d    = pc_in;
      sp_d    = sp_in;
      f_d     = f_in;
      ime_d   = ime_in;
      probe_d = probe_in;
      fcnt_d  = fcnt_q + 1'b1;
    end

    if (trace_clr) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      wrap_d = 1'b0;
    end else if (push) begin
      wptr_d = wptr_q + 1'b1;
      if (full) begin
        // Oldest entry is overwritten: drag the read pointer along.
        rptr_d = rptr_q + 1'b1;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (pop) begin
      data_d  = mem[rptr_q];
      valid_d = 1'b1;
      rptr_d  = rptr_q + 1'b1;
      cnt_d   = cnt_q - 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      pc_q    <= '0;
      sp_q    <= '0;
      f_q     <= '0;
      ime_q   <= 1'b0;
      probe_q <= '0;
      fcnt_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      f_q     <= f_d;
      ime_q   <= ime_d;
      probe_q <= probe_d;
      fcnt_q  <= fcnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign pc          = pc_q;
  assign sp          = sp_q;
  assign f           = f_q;
  assign ime         = ime_q;
  assign probe       = probe_q;
  assign trace_data  = data_q;
  assign trace_valid = valid_q;
  assign trace_cnt   = cnt_q;
  assign trace_wrap  = wrap_q;
  assign fetch_cnt   = fcnt_q;

endmodule
